// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes one instruction into ALU/memory controls with a load-use bubble.
// Optional macro WB_BYPASS_EN forwards the same-cycle write-back value into opA/opB on accept.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [15:0] imm16,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] readData1,
   input  logic [31:0] readData2,
   input  logic        wbRegWrite,
   input  logic [4:0]  wbWriteRegister,
   input  logic [31:0] wbWriteData,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        flush,
   output logic [31:0] opA,
   output logic [31:0] opB,
   output logic [31:0] immExt,
   output logic [4:0]  destReg,
   output logic [3:0]  aluCtrl,
   output logic        aluSrcImm,
   output logic        regWriteOut,
   output logic        memReadOut,
   output logic        memWriteOut
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   logic        r_out_valid;
   logic [31:0] r_opA, r_opB, r_immExt;
   logic [4:0]  r_destReg;
   logic [3:0]  r_aluCtrl;
   logic        r_aluSrcImm, r_regWrite, r_memRead, r_memWrite;

   logic [4:0]  w_dest;
   logic [3:0]  w_alu;
   logic        w_src_imm, w_reg_write, w_mem_read, w_mem_write;
   logic        w_zero_ext, w_uses_rt;
   logic [31:0] w_imm_ext, w_opA, w_opB;
   logic        w_hazard, w_accept;

   always_comb begin
      w_dest      = 5'd0;
      w_alu       = 4'b0000;
      w_src_imm   = 1'b0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_zero_ext  = 1'b0;
      w_uses_rt   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            w_dest      = rd;
            w_uses_rt   = 1'b1;
            w_reg_write = 1'b1;
            case (funct)
               6'h20:   w_alu = 4'b0010;
               6'h22:   w_alu = 4'b0110;
               6'h24:   w_alu = 4'b0000;
               6'h25:   w_alu = 4'b0001;
               6'h2A:   w_alu = 4'b0111;
               default: begin
                  w_alu       = 4'b1111;
                  w_reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            w_dest      = rt;
            w_src_imm   = 1'b1;
            w_alu       = 4'b0010;
            w_reg_write = 1'b1;
         end
         OP_ORI: begin
            w_dest      = rt;
            w_src_imm   = 1'b1;
            w_zero_ext  = 1'b1;
            w_alu       = 4'b0001;
            w_reg_write = 1'b1;
         end
         OP_LW: begin
            w_dest      = rt;
            w_src_imm   = 1'b1;
            w_alu       = 4'b0010;
            w_reg_write = 1'b1;
            w_mem_read  = 1'b1;
         end
         OP_SW: begin
            w_src_imm   = 1'b1;
            w_alu       = 4'b0010;
            w_mem_write = 1'b1;
            w_uses_rt   = 1'b1;
         end
         OP_BEQ: begin
            w_alu       = 4'b0110;
            w_uses_rt   = 1'b1;
         end
         default: ;
      endcase
      // $zero is never a real destination
      if (w_dest == 5'd0) w_reg_write = 1'b0;
   end

   assign w_imm_ext = w_zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

`ifdef WB_BYPASS_EN
   assign w_opA = (wbRegWrite && wbWriteRegister != 5'd0 && wbWriteRegister == rs) ? wbWriteData : readData1;
   assign w_opB = (wbRegWrite && wbWriteRegister != 5'd0 && wbWriteRegister == rt) ? wbWriteData : readData2;
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{wbRegWrite, wbWriteRegister, wbWriteData};
   assign w_opA = readData1;
   assign w_opB = readData2;
`endif

   // Load-use: the load in the stage has not produced its data yet
   assign w_hazard = in_valid && r_out_valid && r_memRead && (r_destReg != 5'd0) &&
                     ((r_destReg == rs) || (w_uses_rt && r_destReg == rt));
   assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush && !reset;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_opA       <= '0;
         r_opB       <= '0;
         r_immExt    <= '0;
         r_destReg   <= '0;
         r_aluCtrl   <= '0;
         r_aluSrcImm <= 1'b0;
         r_regWrite  <= 1'b0;
         r_memRead   <= 1'b0;
         r_memWrite  <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_opA       <= w_opA;
         r_opB       <= w_opB;
         r_immExt    <= w_imm_ext;
         r_destReg   <= w_dest;
         r_aluCtrl   <= w_alu;
         r_aluSrcImm <= w_src_imm;
         r_regWrite  <= w_reg_write;
         r_memRead   <= w_mem_read;
         r_memWrite  <= w_mem_write;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign opA         = r_opA;
   assign opB         = r_opB;
   assign immExt      = r_immExt;
   assign destReg     = r_destReg;
   assign aluCtrl     = r_aluCtrl;
   assign aluSrcImm   = r_aluSrcImm;
   assign regWriteOut = r_regWrite;
   assign memReadOut  = r_memRead;
   assign memWriteOut = r_memWrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, load-use bubble, hold, bypass, flush and reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready;
   logic [5:0]  opcode, funct;
   logic [15:0] imm16;
   logic [4:0]  rs, rt, rd;
   logic [31:0] readData1, readData2;
   logic        wbRegWrite;
   logic [4:0]  wbWriteRegister;
   logic [31:0] wbWriteData;
   logic        out_valid, out_ready, flush;
   logic [31:0] opA, opB, immExt;
   logic [4:0]  destReg;
   logic [3:0]  aluCtrl;
   logic        aluSrcImm, regWriteOut, memReadOut, memWriteOut;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct(funct), .imm16(imm16), .rs(rs), .rt(rt), .rd(rd),
      .readData1(readData1), .readData2(readData2),
      .wbRegWrite(wbRegWrite), .wbWriteRegister(wbWriteRegister), .wbWriteData(wbWriteData),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .opA(opA), .opB(opB), .immExt(immExt), .destReg(destReg), .aluCtrl(aluCtrl),
      .aluSrcImm(aluSrcImm), .regWriteOut(regWriteOut),
      .memReadOut(memReadOut), .memWriteOut(memWriteOut)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                          input logic [4:0] t, input logic [4:0] d, input logic [15:0] imm,
                          input logic [31:0] d1, input logic [31:0] d2);
      in_valid  = 1'b1;
      opcode    = op;
      funct     = fn;
      rs        = s;
      rt        = t;
      rd        = d;
      imm16     = imm;
      readData1 = d1;
      readData2 = d2;
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; imm16 = '0;
      rs = '0; rt = '0; rd = '0; readData1 = '0; readData2 = '0;
      wbRegWrite = 1'b0; wbWriteRegister = '0; wbWriteData = '0;
      out_ready = 1'b1; flush = 1'b0;

      // Reset, with an instruction presented that must be discarded
      present(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0001, 32'd1, 32'd2);
      check("rst_in_ready", in_ready, 0);
      tick();
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_opA", opA, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      check("rst_drop", out_valid, 0);

      // addi rs=1 rt=2 imm=-1
      present(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 16'hFFFF, 32'd5, 32'd9);
      check("addi_in_ready", in_ready, 1);
      tick();
      check("addi_valid", out_valid, 1);
      check("addi_opA", opA, 32'd5);
      check("addi_opB", opB, 32'd9);
      check("addi_imm", immExt, 32'hFFFF_FFFF);
      check("addi_dest", destReg, 2);
      check("addi_alu", aluCtrl, 4'b0010);
      check("addi_srcimm", aluSrcImm, 1);
      check("addi_regw", regWriteOut, 1);
      check("addi_memr", memReadOut, 0);

      // ori zero-extends
      present(6'h0D, 6'h00, 5'd1, 5'd4, 5'd0, 16'h8001, 32'd0, 32'd0);
      tick();
      check("ori_imm", immExt, 32'h0000_8001);
      check("ori_alu", aluCtrl, 4'b0001);
      check("ori_dest", destReg, 4);

      // R-type variants
      present(6'h00, 6'h22, 5'd1, 5'd2, 5'd5, 16'h0000, 32'd0, 32'd0);
      tick();
      check("sub_alu", aluCtrl, 4'b0110);
      check("sub_dest", destReg, 5);
      check("sub_regw", regWriteOut, 1);
      check("sub_srcimm", aluSrcImm, 0);
      present(6'h00, 6'h2A, 5'd1, 5'd2, 5'd6, 16'h0000, 32'd0, 32'd0);
      tick();
      check("slt_alu", aluCtrl, 4'b0111);
      present(6'h00, 6'h3F, 5'd1, 5'd2, 5'd6, 16'h0000, 32'd0, 32'd0);
      tick();
      check("badfn_alu", aluCtrl, 4'b1111);
      check("badfn_regw", regWriteOut, 0);
      present(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 16'h0000, 32'd0, 32'd0);
      tick();
      check("rd0_regw", regWriteOut, 0);

      // beq and unknown opcode
      present(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0003, 32'd0, 32'd0);
      tick();
      check("beq_alu", aluCtrl, 4'b0110);
      check("beq_srcimm", aluSrcImm, 0);
      check("beq_regw", regWriteOut, 0);
      present(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0003, 32'd0, 32'd0);
      tick();
      check("nop_ctl", {regWriteOut, memReadOut, memWriteOut}, 3'b000);

      // Load-use bubble: lw r3 then add using r3
      present(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 16'h0004, 32'd0, 32'd0);
      tick();
      check("lw_memr", memReadOut, 1);
      check("lw_dest", destReg, 3);
      present(6'h00, 6'h20, 5'd3, 5'd6, 5'd7, 16'h0000, 32'd0, 32'd0);
      check("haz_in_ready", in_ready, 0);
      tick();
      check("haz_bubble", out_valid, 0);
      check("haz_retry_ready", in_ready, 1);
      tick();
      check("haz_add_valid", out_valid, 1);
      check("haz_add_dest", destReg, 7);

      // sw held under backpressure
      present(6'h2B, 6'h00, 5'd2, 5'd8, 5'd0, 16'h0010, 32'h100, 32'h55);
      tick();
      check("sw_memw", memWriteOut, 1);
      check("sw_regw", regWriteOut, 0);
      out_ready = 1'b0;
      present(6'h08, 6'h00, 5'd1, 5'd9, 5'd0, 16'h0002, 32'hAAAA, 32'hBBBB);
      for (int i = 0; i < 4; i++) begin
         check("hold_in_ready", in_ready, 0);
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_opA", opA, 32'h100);
         check("hold_memw", memWriteOut, 1);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
      check("release_opA", opA, 32'hAAAA);
      check("release_dest", destReg, 9);

      // Write-back bypass
      wbRegWrite = 1'b1; wbWriteRegister = 5'd7; wbWriteData = 32'hDEADBEEF;
      present(6'h08, 6'h00, 5'd7, 5'd9, 5'd0, 16'h0001, 32'h0, 32'h77);
      tick();
`ifdef WB_BYPASS_EN
      check("byp_opA", opA, 32'hDEADBEEF);
`else
      check("byp_opA", opA, 32'h0);
`endif
      check("byp_opB", opB, 32'h77);
      wbWriteRegister = 5'd0;
      present(6'h08, 6'h00, 5'd7, 5'd9, 5'd0, 16'h0001, 32'h1234, 32'h77);
      tick();
      check("byp_r0_opA", opA, 32'h1234);
      wbRegWrite = 1'b0;

      // Flush with in_valid on a valid entry
      flush = 1'b1;
      present(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0001, 32'h99, 32'h0);
      check("flush_in_ready", in_ready, 0);
      tick();
      check("flush_valid", out_valid, 0);
      check("flush_no_load", opA, 32'h1234);
      flush = 1'b0;

      // Drain with no new instruction
      tick();
      check("post_flush_load", out_valid, 1);
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);

      // Reset mid-stream clears everything
      present(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 16'h8000, 32'h11, 32'h22);
      tick();
      check("pre_rst_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check("rst2_in_ready", in_ready, 0);
      tick();
      check("rst2_valid", out_valid, 0);
      check("rst2_opA", opA, 0);
      check("rst2_opB", opB, 0);
      check("rst2_imm", immExt, 0);
      check("rst2_dest", destReg, 0);
      check("rst2_alu", aluCtrl, 0);
      check("rst2_bits", {aluSrcImm, regWriteOut, memReadOut, memWriteOut}, 4'b0000);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      check("rst2_discard", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
